// File: rtl/seq_11011_frame_tx.sv
// Serial frame transmitter: sync word 11011, then a zero-stuffed MSB-first payload,
// paced by a bit-rate strobe. Registered outputs; the FSM state is visible on dbg_state.
module seq_11011_frame_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              bit_en,
    output logic              serial_out,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        dbg_state
);
    localparam int         IDX_W      = $clog2(DATA_W + 1);
    localparam logic [4:0] SYNC_PAT   = 5'b11011;
    localparam logic [3:0] STUFF_HIST = 4'b1101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_SYNC  = 3'd2,
        ST_DATA  = 3'd3,
        ST_STUFF = 3'd4
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_data;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [2:0]        r_sync_idx;
    logic [3:0]        r_hist;
    logic              r_serial;
    logic              r_busy;
    logic              r_done;
    logic              r_ready;
    logic              w_take;

    // Handshake: a word moves when data_valid and data_ready are both high at a rising edge.
    assign w_take = data_valid && r_ready && (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_bit_idx  <= '0;
            r_sync_idx <= '0;
            r_hist     <= '0;
            r_serial   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_data  <= data_in;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ARMED;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (bit_en) begin
                        r_serial   <= SYNC_PAT[4];
                        r_sync_idx <= 3'd1;
                        r_state    <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (bit_en) begin
                        if (r_sync_idx == 3'd5) begin
                            // First payload bit also seeds the stuffing history.
                            r_serial  <= r_data[DATA_W-1];
                            r_data    <= {r_data[DATA_W-2:0], 1'b0};
                            r_hist    <= {3'b000, r_data[DATA_W-1]};
                            r_bit_idx <= IDX_W'(DATA_W - 1);
                            r_state   <= ST_DATA;
                        end else begin
                            r_serial   <= SYNC_PAT[3'd4 - r_sync_idx];
                            r_sync_idx <= r_sync_idx + 3'd1;
                        end
                    end
                end
                ST_DATA, ST_STUFF: begin
                    if (bit_en) begin
                        if (r_bit_idx == '0) begin
                            r_serial <= 1'b0;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else if (r_hist == STUFF_HIST) begin
                            r_serial <= 1'b0;
                            r_hist   <= {r_hist[2:0], 1'b0};
                            r_state  <= ST_STUFF;
                        end else begin
                            r_serial  <= r_data[DATA_W-1];
                            r_data    <= {r_data[DATA_W-2:0], 1'b0};
                            r_hist    <= {r_hist[2:0], r_data[DATA_W-1]};
                            r_bit_idx <= r_bit_idx - IDX_W'(1);
                            r_state   <= ST_DATA;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_serial <= 1'b0;
                    r_busy   <= 1'b0;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready = r_ready;
    assign serial_out = r_serial;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign dbg_state  = r_state;

endmodule
